// File: rtl/window_3x3_generator_if.sv
// Pixel-in / window-out bundle between the raster source, the 3x3 window
// generator and the downstream filters.
interface window_3x3_generator_if;
  logic [11:0]  pixel_in;
  logic         pixel_valid;
  logic         frame_start;
  logic         in_ready;
  logic [107:0] window_out;
  logic         window_valid;
  logic [10:0]  center_x;
  logic [9:0]   center_y;
  logic         frame_done;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  in_ready, window_out, window_valid, center_x, center_y, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output in_ready, window_out, window_valid, center_x, center_y, frame_done
  );
endinterface

// File: rtl/window_3x3_generator.sv
// Raster stream to 3x3 RGB444 neighbourhoods using two line buffers and a
// two-column register window; flushes one row plus one beat after each frame.
//   state  | meaning
//   IDLE   | waiting for a beat tagged frame_start
//   STREAM | accepting frame pixels in raster order
//   FLUSH  | injecting IMG_WIDTH+1 zero beats, input stalled
module window_3x3_generator #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic reset,
  window_3x3_generator_if.slave win_if
);
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = $clog2(IMG_WIDTH + 2);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] PRIMED  = CW'(IMG_WIDTH + 1);
  localparam logic [CW-1:0] FL_LOAD = CW'(IMG_WIDTH);
  localparam logic [10:0]   CX_LAST = 11'(IMG_WIDTH - 1);
  localparam logic [9:0]    CY_LAST = 10'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t        state_q;
  logic [XW-1:0] in_x_q;
  logic [YW-1:0] in_y_q;
  logic [CW-1:0] beat_cnt_q;
  logic [CW-1:0] flush_cnt_q;
  logic [10:0]   out_x_q;
  logic [9:0]    out_y_q;
  // Columns packed {top, mid, bottom}; col_a is one column left of the newest
  logic [35:0]   col_a_q, col_b_q;
  logic [11:0]   lb1 [IMG_WIDTH];
  logic [11:0]   lb2 [IMG_WIDTH];
  logic [107:0]  window_out_q;
  logic          window_valid_q, frame_done_q;
  logic [10:0]   center_x_q;
  logic [9:0]    center_y_q;

  logic          accept, start, beat, emit;
  logic [XW-1:0] x_eff;
  logic [YW-1:0] y_eff;
  logic [11:0]   pix;
  logic [35:0]   col_new;
  logic          l_ok, r_ok, u_ok, d_ok;
  logic [107:0]  win_d;

  function automatic logic [11:0] keep(input logic ok, input logic [11:0] v);
    return ok ? v : 12'h000;
  endfunction

  assign accept  = win_if.pixel_valid && (state_q != S_FLUSH);
  assign start   = accept && win_if.frame_start;
  assign beat    = (state_q == S_FLUSH) || start || (accept && state_q == S_STREAM);
  assign x_eff   = start ? '0 : in_x_q;
  assign y_eff   = start ? '0 : in_y_q;
  assign pix     = (state_q == S_FLUSH) ? 12'h000 : win_if.pixel_in;
  assign col_new = {lb2[x_eff], lb1[x_eff], pix};
  assign emit    = beat && !start && (beat_cnt_q == PRIMED);

  assign l_ok = (out_x_q != 11'd0);
  assign r_ok = (out_x_q != CX_LAST);
  assign u_ok = (out_y_q != 10'd0);
  assign d_ok = (out_y_q != CY_LAST);

  assign win_d = {col_a_q[23:12],
                  keep(l_ok, col_b_q[23:12]),
                  keep(r_ok, col_new[23:12]),
                  keep(u_ok, col_a_q[35:24]),
                  keep(d_ok, col_a_q[11:0]),
                  keep(u_ok && l_ok, col_b_q[35:24]),
                  keep(u_ok && r_ok, col_new[35:24]),
                  keep(d_ok && l_ok, col_b_q[11:0]),
                  keep(d_ok && r_ok, col_new[11:0])};

  always_ff @(posedge clk) begin
    if (beat) begin
      lb1[x_eff] <= pix;
      lb2[x_eff] <= lb1[x_eff];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      in_x_q         <= '0;
      in_y_q         <= '0;
      beat_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      col_a_q        <= '0;
      col_b_q        <= '0;
      window_out_q   <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      center_x_q     <= '0;
      center_y_q     <= '0;
    end else begin
      window_valid_q <= emit;
      frame_done_q   <= emit && (out_x_q == CX_LAST) && (out_y_q == CY_LAST);
      if (emit) begin
        window_out_q <= win_d;
        center_x_q   <= out_x_q;
        center_y_q   <= out_y_q;
      end

      if (beat) begin
        col_a_q <= col_new;
        col_b_q <= col_a_q;
        in_x_q  <= (x_eff == X_LAST) ? '0 : x_eff + 1'b1;
        in_y_q  <= (x_eff == X_LAST) ? y_eff + 1'b1 : y_eff;
        if (start)
          beat_cnt_q <= CW'(1);
        else if (beat_cnt_q != PRIMED)
          beat_cnt_q <= beat_cnt_q + 1'b1;

        if (start) begin
          out_x_q <= '0;
          out_y_q <= '0;
        end else if (emit) begin
          if (out_x_q == CX_LAST) begin
            out_x_q <= '0;
            out_y_q <= (out_y_q == CY_LAST) ? 10'd0 : out_y_q + 1'b1;
          end else begin
            out_x_q <= out_x_q + 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE: if (start) state_q <= S_STREAM;
        S_STREAM: begin
          if (accept && x_eff == X_LAST && y_eff == Y_LAST) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= FL_LOAD;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) state_q <= S_IDLE;
          else                   flush_cnt_q <= flush_cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign win_if.in_ready     = (state_q != S_FLUSH);
  assign win_if.window_out   = window_out_q;
  assign win_if.window_valid = window_valid_q;
  assign win_if.center_x     = center_x_q;
  assign win_if.center_y     = center_y_q;
  assign win_if.frame_done   = frame_done_q;
endmodule

// File: tb/tb_window_3x3_generator.sv
// Scoreboard bench for window_3x3_generator at 4x3: expected windows are
// computed from a frame image array and compared as the DUT emits them.
module tb_window_3x3_generator;
  localparam int W = 4;
  localparam int H = 3;

  logic clk;
  logic reset;
  window_3x3_generator_if bus();

  window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .win_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [107:0] win;
    int           cx;
    int           cy;
    bit           done;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [11:0]  img [H][W];
  bit           tog_mode = 0;
  bit           lat_mode = 0;
  bit           cap_mode = 0;
  int           acc_cnt  = 0;
  bit           prev_valid = 0;
  logic [107:0] cap_win [W][H];
  bit           cap_done [W][H];

  task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %0s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return img[y][x];
  endfunction

  function automatic logic [107:0] ref_win(input int cx, input int cy);
    return {px(cx, cy), px(cx-1, cy), px(cx+1, cy), px(cx, cy-1), px(cx, cy+1),
            px(cx-1, cy-1), px(cx+1, cy-1), px(cx-1, cy+1), px(cx+1, cy+1)};
  endfunction

  always @(posedge clk)
    if (lat_mode && bus.pixel_valid && bus.in_ready) acc_cnt++;

  // Monitor: pops the scoreboard on every presented window
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.window_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_window: got cx=%0d cy=%0d want none", bus.center_x, bus.center_y);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("window_out", bus.window_out, e.win);
          chk("center_x", 108'(bus.center_x), 108'(e.cx));
          chk("center_y", 108'(bus.center_y), 108'(e.cy));
          chk("frame_done", 108'(bus.frame_done), 108'(e.done));
          if (cap_mode && int'(bus.center_x) < W && int'(bus.center_y) < H) begin
            cap_win[bus.center_x][bus.center_y]  = bus.window_out;
            cap_done[bus.center_x][bus.center_y] = bus.frame_done;
          end
        end
        if (tog_mode) chk("no_back_to_back", 108'(prev_valid), 108'(0));
      end else begin
        chk("frame_done_without_window", 108'(bus.frame_done), 108'(0));
      end
      if (lat_mode) chk("first_window_latency", 108'(bus.window_valid), 108'(acc_cnt >= 6));
      prev_valid = bus.window_valid;
    end
  end

  task automatic drive_beat(input logic [11:0] p, input bit fs);
    int g;
    bus.pixel_in    = p;
    bus.pixel_valid = 1'b1;
    bus.frame_start = fs;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("in_ready_timeout", 108'(bus.in_ready), 108'(1));
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic gap_cycle();
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'($urandom_range(0, 1));
    bus.pixel_in    = 12'($urandom);
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
  endtask

  // mode 0: test-plan pixels, 1: random; style 0: continuous, 1: toggle, 2: random gaps
  task automatic run_frame(input int mode, input int abort_k, input int style);
    int n, nwin;
    exp_t e;
    n    = (abort_k > 0) ? abort_k : W*H;
    nwin = (abort_k > 0) ? abort_k - W - 1 : W*H;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (mode == 0) ? 12'(y*16 + x + 1) : 12'($urandom);
    for (int c = 0; c < nwin; c++) begin
      e.cx   = c % W;
      e.cy   = c / W;
      e.win  = ref_win(e.cx, e.cy);
      e.done = (abort_k == 0) && (c == W*H - 1);
      q.push_back(e);
    end
    if (style == 1) tog_mode = 1;
    for (int i = 0; i < n; i++) begin
      drive_beat(img[i / W][i % W], i == 0);
      if (i == n - 1) begin
        tog_mode = 0;
        lat_mode = 0;
      end else if (style == 1) begin
        gap_cycle();
      end else if (style == 2 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) gap_cycle();
      end
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) chk("drain_timeout", 108'(q.size()), 108'(0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    reset = 1'b1;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 108'(bus.in_ready), 108'(1));
    chk("rst_window_valid", 108'(bus.window_valid), 108'(0));
    chk("rst_window_out", bus.window_out, 108'(0));
    chk("rst_center_x", 108'(bus.center_x), 108'(0));
    chk("rst_center_y", 108'(bus.center_y), 108'(0));
    chk("rst_frame_done", 108'(bus.frame_done), 108'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Untagged beats in IDLE must be discarded
    repeat (3) drive_beat(12'($urandom), 1'b0);

    cap_mode = 1;
    lat_mode = 1;
    run_frame(0, 0, 0);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      low++;
    end
    chk("flush_ready_low_cycles", 108'(low), 108'(W + 1));
    wait_drain();
    cap_mode = 0;
    chk("plan_win_0_0", cap_win[0][0], 108'h001_000_002_000_011_000_000_000_012);
    chk("plan_win_1_1", cap_win[1][1], 108'h012_011_013_002_022_001_003_021_023);
    chk("plan_win_3_2", cap_win[3][2], 108'h024_023_000_014_000_013_000_000_000);
    chk("plan_done_3_2", 108'(cap_done[3][2]), 108'(1));

    run_frame(0, 0, 1);
    wait_drain();

    // Abort at pixel (2,1): beat index 6 starts a fresh frame
    run_frame(0, 6, 0);
    run_frame(1, 0, 0);
    wait_drain();

    run_frame(1, 0, 2);
    wait_drain();

    run_frame(1, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("flush_rst_window_valid", 108'(bus.window_valid), 108'(0));
    chk("flush_rst_in_ready", 108'(bus.in_ready), 108'(1));
    chk("flush_rst_window_out", bus.window_out, 108'(0));
    chk("flush_rst_frame_done", 108'(bus.frame_done), 108'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_frame(0, 0, 0);
    wait_drain();

    chk("scoreboard_empty", 108'(q.size()), 108'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/window_3x3_generator.md
# window_3x3_generator

Raster-to-neighbourhood stage feeding the per-pixel filter modules. Accepts a raster-order stream of 12-bit RGB444 pixels and, using two internal line buffers, produces one 108-bit 3x3 neighbourhood per input pixel position, packed in the layout the filters consume. Out-of-frame neighbours are zero. After the last input pixel it flushes internally to emit the final row's windows.

## Interface
- IMG_WIDTH, 640, pixels per line (2..2048)
- IMG_HEIGHT, 480, lines per frame (2..1024)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- pixel_in  input  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}
- pixel_valid  input  1  pixel_in valid this cycle
- frame_start  input  1  qualifies the beat carrying pixel (0,0)
- in_ready  output  1  beat accepted when pixel_valid && in_ready
- window_out  output  108  packed neighbourhood of centre (cx,cy)
- window_valid  output  1  window_out/center_x/center_y valid this cycle
- center_x  output  11  cx of current window
- center_y  output  10  cy of current window
- frame_done  output  1  one-cycle pulse with the last window of a frame

## Operation
- window_out packing: [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
- Any neighbour with x<0, x>=IMG_WIDTH, y<0 or y>=IMG_HEIGHT is 12'h000; centre always real pixel.
- Storage: two IMG_WIDTH x 12 line buffers (rows y-1, y-2 relative to input) plus 3x3 register window; input counters in_x, in_y; linear beat counter.
- States:
  - IDLE: in_ready=1; beats without frame_start discarded; accepted beat with frame_start -> STREAM as pixel (0,0).
  - STREAM: in_ready=1; each accepted beat advances in_x (wrap at IMG_WIDTH, increment in_y). Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) -> FLUSH.
  - FLUSH: in_ready=0; exactly IMG_WIDTH+1 internal zero beats, one per clock; after last -> IDLE.
- Accepted beat with frame_start in STREAM: abort current frame, beat becomes (0,0), no further windows from aborted frame; top-row masking by counters hides stale line-buffer data.
- Window for centre (cx,cy) is emitted by the beat (real or flush) at linear index cy*IMG_WIDTH+cx+IMG_WIDTH+1; beats with index < IMG_WIDTH+1 emit nothing. Exactly IMG_WIDTH*IMG_HEIGHT windows per completed frame, raster order.
- No output backpressure; downstream always accepts.
- pixel_valid low in STREAM: pipeline holds, no window emitted.

## Timing
- Reset values: state IDLE, in_ready=1, window_out=0, window_valid=0, center_x=0, center_y=0, frame_done=0, counters 0. Line buffers need not be cleared.
- in_ready combinational from state: low only in FLUSH.
- Outputs registered: window_valid, window_out, center_x, center_y asserted the cycle after the producing beat.
- frame_done coincides with window_valid for centre (IMG_WIDTH-1, IMG_HEIGHT-1).
- Input-to-output latency: IMG_WIDTH+1 accepted beats + 1 clock.
- FLUSH lasts exactly IMG_WIDTH+1 cycles; first accepting cycle after FLUSH is back-to-back in IDLE.
- Reset mid-frame or mid-FLUSH: all outputs to reset values immediately; no partial windows afterwards.

## Test plan
Use IMG_WIDTH=4, IMG_HEIGHT=3, pixel (x,y) = y*16+x+1.
- Continuous frame, frame_start on first beat -> first window_valid one cycle after 6th accepted beat; centre(0,0)=12'h001, right=002, down=011, down-right=012, all other fields 000.
- Same frame -> 12 windows total; centre (1,1) window = up-left 001, up 002, up-right 003, left 011, centre 012, right 013, down-left 021, down 022, down-right 023.
- End of frame -> in_ready low for exactly 5 cycles after accepting (3,2); last window centre 12'h024 with down/right fields 000 and frame_done high that cycle.
- pixel_valid toggled 1/0 every cycle -> identical window sequence, window_valid never on two consecutive cycles.
- frame_start reasserted at pixel (2,1) -> aborted frame emits no more windows; next windows match a fresh frame starting at that beat, top-row up fields 000.
- Reset asserted during FLUSH -> window_valid=0, in_ready=1 next edge; new frame after reset produces correct first window.
